// File: rtl/fxp_ln.sv
// fxp_ln: iterative fixed-point natural logarithm y = ln(x), Q(31-F).F in and out.
// Normalise x = m*2^k, extract log2(m) one bit per cycle by repeated squaring,
// then scale the log2 value by ln2 with round-half-up.
// Optional build macro: LN_DOMAIN_ERR_EN adds the m_axis_data_tuser domain-error flag.
module fxp_ln #(
    parameter int FRAC_BITS  = 12,
    parameter int GUARD_BITS = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_data_tdata,
    input  logic        s_axis_data_tvalid,
    output logic        s_axis_data_tready,
    output logic [31:0] m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready
`ifdef LN_DOMAIN_ERR_EN
    ,
    output logic        m_axis_data_tuser
`endif
);

    localparam int ITERS = FRAC_BITS + GUARD_BITS;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [31:0] LN2_Q32 = 32'hB17217F8;

    typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, DONE} state_t;

    state_t             state;
    logic [31:0]        x_q;
    logic signed [7:0]  k_q;
    logic [31:0]        m_q;
    logic [ITERS-1:0]   frac_q;
    logic [CW-1:0]      cnt;

    logic [4:0]         lead;
    logic [31:0]        m_norm;
    logic signed [7:0]  k_norm;
    logic [63:0]        sq;
    logic [31:0]        m_sq;
    logic signed [39:0] l_val;
    logic signed [71:0] p_val;
    logic [71:0]        rnd;
    logic [31:0]        result;
    logic               unused_bits;

    // Leading-one index of the latched operand (operand is known positive here)
    always_comb begin
        lead = '0;
        for (int i = 0; i < 31; i++) begin
            if (x_q[i]) lead = 5'(i);
        end
    end

    assign m_norm = x_q << (5'd30 - lead);
    assign k_norm = 8'({3'b000, lead}) - 8'(FRAC_BITS);

    // Square of the mantissa; Q2.30 * Q2.30 -> Q4.60, keep Q2.30 window
    assign sq   = {32'd0, m_q} * {32'd0, m_q};
    assign m_sq = sq[61:30];

    // log2 value in units of 2^-(F+G); low bits of the shifted exponent are zero
    assign l_val  = ($signed({{32{k_q[7]}}, k_q}) <<< ITERS)
                  + $signed({{(40-ITERS){1'b0}}, frac_q});
    assign p_val  = $signed({{32{l_val[39]}}, l_val}) * $signed({40'd0, LN2_Q32});
    assign rnd    = p_val + (72'sd1 <<< (31 + GUARD_BITS));
    assign result = rnd[32+GUARD_BITS +: 32];

    assign unused_bits = ^{sq[63:62], sq[29:0], rnd[71:64+GUARD_BITS], rnd[31+GUARD_BITS:0]};

    // Main control FSM and datapath registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state              <= IDLE;
            s_axis_data_tready <= 1'b1;
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tdata  <= '0;
            x_q                <= '0;
            k_q                <= '0;
            m_q                <= '0;
            frac_q             <= '0;
            cnt                <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_data_tvalid) begin
                        x_q                <= s_axis_data_tdata;
                        s_axis_data_tready <= 1'b0;
                        if ($signed(s_axis_data_tdata) <= 32'sd0) begin
                            m_axis_data_tdata  <= 32'h8000_0000;
                            m_axis_data_tvalid <= 1'b1;
                            state              <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    k_q    <= k_norm;
                    m_q    <= m_norm;
                    frac_q <= '0;
                    cnt    <= '0;
                    state  <= ITER;
                end
                ITER: begin
                    frac_q <= {frac_q[ITERS-2:0], m_sq[31]};
                    m_q    <= m_sq[31] ? (m_sq >> 1) : m_sq;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1)) state <= SCALE;
                end
                SCALE: begin
                    m_axis_data_tdata  <= result;
                    m_axis_data_tvalid <= 1'b1;
                    state              <= DONE;
                end
                DONE: begin
                    if (m_axis_data_tready) begin
                        m_axis_data_tvalid <= 1'b0;
                        s_axis_data_tready <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LN_DOMAIN_ERR_EN
    // Domain-error flag, loaded alongside the result and held with it
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_data_tuser <= 1'b0;
        end else if (state == IDLE && s_axis_data_tvalid) begin
            m_axis_data_tuser <= ($signed(s_axis_data_tdata) <= 32'sd0);
        end
    end
`endif

endmodule
